// File: rtl/sprite_pixel_mixer_if.sv
// Pixel-mixer bus: per-pixel layer inputs and raw syncs in, VGA colour, delayed syncs
// and the per-frame collision report out.
interface sprite_pixel_mixer_if #(
  parameter int NUM_LAYERS = 4
);
  logic                    video_on;
  logic                    hsync_in;
  logic                    vsync_in;
  logic                    frame_start;
  logic [3*NUM_LAYERS-1:0] layer_rgb;
  logic [NUM_LAYERS-1:0]   layer_valid;
  logic [2:0]              bg_rgb;
  logic [11:0]             vga_rgb;
  logic                    hsync_out;
  logic                    vsync_out;
  logic [NUM_LAYERS-1:0]   collision_mask;
  logic                    collision_irq;

  modport master (
    output video_on, hsync_in, vsync_in, frame_start, layer_rgb, layer_valid, bg_rgb,
    input  vga_rgb, hsync_out, vsync_out, collision_mask, collision_irq
  );

  modport slave (
    input  video_on, hsync_in, vsync_in, frame_start, layer_rgb, layer_valid, bg_rgb,
    output vga_rgb, hsync_out, vsync_out, collision_mask, collision_irq
  );
endinterface

// File: rtl/sprite_pixel_mixer.sv
// Two-stage sprite priority mixer with blanking and matched sync delay.
// Define MIXER_COLLISION_EN to build the per-frame sprite-overlap mask and irq.
module sprite_pixel_mixer #(
  parameter int   NUM_LAYERS = 4,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  sprite_pixel_mixer_if.slave bus
);

  logic [2:0]  sel_next;
  logic [2:0]  sel_rgb;
  logic        video_on_d;
  logic        hsync_d;
  logic        vsync_d;
  logic [11:0] vga_rgb_q;
  logic        hsync_q;
  logic        vsync_q;

  // Scan from the lowest-priority layer up so the lowest valid index wins.
  always_comb begin
    sel_next = bus.bg_rgb;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (bus.layer_valid[i]) begin
        sel_next = bus.layer_rgb[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_rgb    <= 3'b000;
      video_on_d <= 1'b0;
      hsync_d    <= SYNC_IDLE;
      vsync_d    <= SYNC_IDLE;
      vga_rgb_q  <= 12'h000;
      hsync_q    <= SYNC_IDLE;
      vsync_q    <= SYNC_IDLE;
    end else begin
      sel_rgb    <= sel_next;
      video_on_d <= bus.video_on;
      hsync_d    <= bus.hsync_in;
      vsync_d    <= bus.vsync_in;
      vga_rgb_q  <= video_on_d ? {{4{sel_rgb[2]}}, {4{sel_rgb[1]}}, {4{sel_rgb[0]}}} : 12'h000;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
    end
  end

  assign bus.vga_rgb   = vga_rgb_q;
  assign bus.hsync_out = hsync_q;
  assign bus.vsync_out = vsync_q;

`ifdef MIXER_COLLISION_EN
  logic [3:0]            valid_count;
  logic [NUM_LAYERS-1:0] overlap;
  logic [NUM_LAYERS-1:0] accum;
  logic [NUM_LAYERS-1:0] mask_q;
  logic                  irq_q;

  always_comb begin
    valid_count = 4'd0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      valid_count = valid_count + 4'(bus.layer_valid[i]);
    end
    overlap = (bus.video_on && valid_count >= 4'd2) ? bus.layer_valid : '0;
  end

  // The frame_start pixel opens the new frame, so its overlap seeds the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else if (bus.frame_start) begin
      mask_q <= accum;
      accum  <= overlap;
      irq_q  <= |accum;
    end else begin
      accum  <= accum | overlap;
      irq_q  <= 1'b0;
    end
  end

  assign bus.collision_mask = mask_q;
  assign bus.collision_irq  = irq_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = bus.frame_start;

  assign bus.collision_mask = '0;
  assign bus.collision_irq  = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pixel_mixer.sv
// Bench for sprite_pixel_mixer: vector table, hand-written frame/sync/reset sequences
// and random pixels, all checked against a frame-level reference model.
module tb_sprite_pixel_mixer;

`ifdef MIXER_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  typedef struct {
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic [11:0] layer_rgb;
    logic [3:0]  layer_valid;
    logic [2:0]  bg_rgb;
  } pix_t;

  typedef struct {
    logic        video_on;
    logic [3:0]  valid;
    logic [11:0] rgb;
    logic [2:0]  bg;
    logic [11:0] expect_rgb;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pix_t       cur;
  pix_t       pipe[$];
  logic [3:0] frame_pix[$];
  logic [3:0] exp_mask;
  logic       exp_irq;

  sprite_pixel_mixer_if #(.NUM_LAYERS(4)) bus ();

  sprite_pixel_mixer #(.NUM_LAYERS(4), .SYNC_IDLE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pix_t mk(input logic vo, input logic [3:0] valid,
                              input logic [11:0] rgb, input logic [2:0] bg);
    pix_t p;
    p.video_on    = vo;
    p.hsync       = 1'b1;
    p.vsync       = 1'b1;
    p.frame_start = 1'b0;
    p.layer_rgb   = rgb;
    p.layer_valid = valid;
    p.bg_rgb      = bg;
    return p;
  endfunction

  function automatic logic [2:0] pick(input pix_t p);
    for (int i = 0; i < 4; i++) begin
      if (p.layer_valid[i]) return p.layer_rgb[3*i +: 3];
    end
    return p.bg_rgb;
  endfunction

  function automatic logic [11:0] expand(input logic [2:0] c);
    return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input pix_t p);
    cur             = p;
    bus.video_on    = p.video_on;
    bus.hsync_in    = p.hsync;
    bus.vsync_in    = p.vsync;
    bus.frame_start = p.frame_start;
    bus.layer_rgb   = p.layer_rgb;
    bus.layer_valid = p.layer_valid;
    bus.bg_rgb      = p.bg_rgb;
  endtask

  task automatic model_reset();
    pipe.delete();
    pipe.push_back(mk(1'b0, 4'h0, 12'h000, 3'b000));
    frame_pix.delete();
    exp_mask = 4'h0;
    exp_irq  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, "_rgb"},   16'(bus.vga_rgb),        16'h000);
    check_output({tag, "_hs"},    16'(bus.hsync_out),      16'h1);
    check_output({tag, "_vs"},    16'(bus.vsync_out),      16'h1);
    check_output({tag, "_mask"},  16'(bus.collision_mask), 16'h0);
    check_output({tag, "_irq"},   16'(bus.collision_irq),  16'h0);
  endtask

  // Advance one clock, update the model with the pixel that was sampled, compare outputs.
  task automatic tick();
    pix_t       old;
    logic [3:0] pub;
    @(posedge clk);
    #1;
    pipe.push_back(cur);
    old = pipe.pop_front();
    if (cur.frame_start) begin
      pub = 4'h0;
      foreach (frame_pix[k]) begin
        if ($countones(frame_pix[k]) >= 2) pub = pub | frame_pix[k];
      end
      exp_mask = COLL_EN ? pub : 4'h0;
      exp_irq  = COLL_EN && (pub != 4'h0);
      frame_pix.delete();
    end else begin
      exp_irq = 1'b0;
    end
    if (cur.video_on) frame_pix.push_back(cur.layer_valid);
    check_output("rgb",  16'(bus.vga_rgb), 16'(old.video_on ? expand(pick(old)) : 12'h000));
    check_output("hs",   16'(bus.hsync_out), 16'(old.hsync));
    check_output("vs",   16'(bus.vsync_out), 16'(old.vsync));
    check_output("mask", 16'(bus.collision_mask), 16'(exp_mask));
    check_output("irq",  16'(bus.collision_irq), 16'(exp_irq));
  endtask

  task automatic pulse_frame(input pix_t p);
    pix_t q;
    q = p;
    q.frame_start = 1'b1;
    apply_stimulus(q);
    tick();
    q.frame_start = 1'b0;
    apply_stimulus(q);
  endtask

  initial begin
    vec_t vecs[8];
    pix_t p;
    int   lows;
    int   first;

    errors = 0;
    checks = 0;

    vecs[0] = '{1'b1, 4'b0110, {3'b000, 3'b010, 3'b100, 3'b000}, 3'b000, 12'hF00};
    vecs[1] = '{1'b1, 4'b0000, {3'b111, 3'b111, 3'b111, 3'b111}, 3'b011, 12'h0FF};
    vecs[2] = '{1'b0, 4'b1111, {3'b111, 3'b111, 3'b111, 3'b111}, 3'b111, 12'h000};
    vecs[3] = '{1'b1, 4'b1000, {3'b111, 3'b000, 3'b000, 3'b000}, 3'b000, 12'hFFF};
    vecs[4] = '{1'b1, 4'b1111, {3'b110, 3'b101, 3'b011, 3'b001}, 3'b111, 12'h00F};
    vecs[5] = '{1'b1, 4'b1100, {3'b010, 3'b101, 3'b000, 3'b000}, 3'b000, 12'hF0F};
    vecs[6] = '{1'b1, 4'b0000, {3'b111, 3'b111, 3'b111, 3'b111}, 3'b000, 12'h000};
    vecs[7] = '{1'b1, 4'b0001, {3'b000, 3'b000, 3'b000, 3'b110}, 3'b001, 12'hFF0};

    rst = 1'b1;
    apply_stimulus(mk(1'b0, 4'h0, 12'h000, 3'b000));
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      apply_stimulus(mk(vecs[i].video_on, vecs[i].valid, vecs[i].rgb, vecs[i].bg));
      tick();
      tick();
      check_output("table_rgb", 16'(bus.vga_rgb), 16'(vecs[i].expect_rgb));
    end

    // hsync low for three pixels must appear two clocks later for exactly three clocks.
    lows  = 0;
    first = -1;
    p = mk(1'b1, 4'h0, 12'h000, 3'b101);
    for (int t = 1; t <= 8; t++) begin
      p.hsync = (t <= 3) ? 1'b0 : 1'b1;
      apply_stimulus(p);
      tick();
      if (bus.hsync_out == 1'b0) begin
        lows++;
        if (first < 0) first = t;
      end
    end
    check_output("hsync_low_len",   16'(lows),  16'd3);
    check_output("hsync_low_start", 16'(first), 16'd2);

    // One visible overlap of layers 0 and 3, published at the next frame_start.
    pulse_frame(mk(1'b1, 4'h0, 12'h000, 3'b000));
    tick();
    apply_stimulus(mk(1'b1, 4'b1001, 12'hFFF, 3'b000));
    tick();
    apply_stimulus(mk(1'b1, 4'b0100, 12'h123, 3'b000));
    repeat (3) tick();
    pulse_frame(mk(1'b1, 4'h0, 12'h000, 3'b000));
    check_output("frame_mask", 16'(bus.collision_mask), COLL_EN ? 16'h9 : 16'h0);
    check_output("frame_irq",  16'(bus.collision_irq),  16'(COLL_EN));
    tick();
    check_output("irq_one_clk", 16'(bus.collision_irq),  16'h0);
    check_output("mask_holds",  16'(bus.collision_mask), COLL_EN ? 16'h9 : 16'h0);
    repeat (4) tick();
    pulse_frame(mk(1'b1, 4'b0010, 12'h000, 3'b000));
    check_output("clean_mask", 16'(bus.collision_mask), 16'h0);
    check_output("clean_irq",  16'(bus.collision_irq),  16'h0);
    tick();

    // Blanked overlap is ignored; overlap on the frame_start pixel counts for the new frame.
    apply_stimulus(mk(1'b0, 4'b0011, 12'hFFF, 3'b000));
    repeat (3) tick();
    pulse_frame(mk(1'b1, 4'b0011, 12'hFFF, 3'b000));
    check_output("blank_mask", 16'(bus.collision_mask), 16'h0);
    check_output("blank_irq",  16'(bus.collision_irq),  16'h0);
    apply_stimulus(mk(1'b1, 4'b0000, 12'h000, 3'b010));
    repeat (3) tick();
    pulse_frame(mk(1'b1, 4'b0000, 12'h000, 3'b010));
    check_output("fs_pix_mask", 16'(bus.collision_mask), COLL_EN ? 16'h3 : 16'h0);
    check_output("fs_pix_irq",  16'(bus.collision_irq),  16'(COLL_EN));
    tick();

    for (int n = 0; n < 1500; n++) begin
      p = mk($urandom_range(0, 9) != 0, 4'($urandom), 12'($urandom), 3'($urandom));
      p.hsync       = $urandom_range(0, 15) != 0;
      p.vsync       = $urandom_range(0, 31) != 0;
      p.frame_start = $urandom_range(0, 39) == 0;
      apply_stimulus(p);
      tick();
    end

    // Asynchronous reset mid-stream with syncs held low and a mask published.
    apply_stimulus(mk(1'b1, 4'b0011, 12'hFFF, 3'b000));
    tick();
    pulse_frame(mk(1'b1, 4'b0101, 12'hFFF, 3'b000));
    p = mk(1'b1, 4'b0111, 12'hFFF, 3'b000);
    p.hsync = 1'b0;
    p.vsync = 1'b0;
    apply_stimulus(p);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_reset("midrst");
    #1;
    rst = 1'b0;
    model_reset();
    repeat (3) tick();
    pulse_frame(mk(1'b1, 4'h0, 12'h000, 3'b000));
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
